instruction_fetch_queue: RTL

Second-generation fetch unit for the superscalar front end. It fetches IPC-wide instruction bundles from a variable-latency instruction memory using a request/valid handshake, and buffers them in a QUEUE_DEPTH-entry fetch queue that decouples IM latency from decode back-pressure. It handles taken branches by flushing the queue and discarding stale in-flight responses. It sits between the instruction memory and decode.

---
 rtl/instruction_fetch_queue.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_queue
// Purpose  : Fetches IPC-wide instruction bundles from a variable-latency
//            instruction memory (at most one request in flight). Buffers them
//            in a circular QUEUE_DEPTH-entry queue ahead of decode. Taken
//            branches flush the queue, redirect the PC and discard any stale
//            in-flight response.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   halt              stop issuing IM requests; the queue keeps draining
//   isBranchTaken     one-cycle redirect pulse (highest priority)
//   branchTarget      redirect PC
//   IM_req/IM_address request and bundle address toward instruction memory
//   IM_ready          IM accepts the request when IM_req & IM_ready
//   IM_data           response bundle (slot 0 in the LSBs)
//   IM_dataValid      response valid
//   IF_data/IF_pc     head-of-queue bundle and its PC
//   IF_dataValid      head entry valid
//   IF_ready          decode accepts the head when IF_dataValid & IF_ready
//   queue_count       number of occupied queue entries
// Optional macro FETCH_STATS_EN:
//   stat_fetched      bundles pushed into the queue (wraps at 2^32)
//   stat_discarded    responses dropped because of a redirect (wraps at 2^32)
// ============================================================================
module instruction_fetch_queue #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       INSTR_WIDTH   = 32,
  parameter int                       IPC           = 2,
  parameter int                       QUEUE_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           halt,
  input  logic                           isBranchTaken,
  input  logic [ADDRESS_WIDTH-1:0]       branchTarget,
  output logic                           IM_req,
  output logic [ADDRESS_WIDTH-1:0]       IM_address,
  input  logic                           IM_ready,
  input  logic [IPC*INSTR_WIDTH-1:0]     IM_data,
  input  logic                           IM_dataValid,
  output logic [IPC*INSTR_WIDTH-1:0]     IF_data,
  output logic [ADDRESS_WIDTH-1:0]       IF_pc,
  output logic                           IF_dataValid,
  input  logic                           IF_ready,
`ifdef FETCH_STATS_EN
  output logic [31:0]                    stat_fetched,
  output logic [31:0]                    stat_discarded,
`endif
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_BW    = IPC * INSTR_WIDTH;

  localparam logic [c_PTR_W-1:0]       c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0]       c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]       c_DEPTH   = c_CNT_W'(QUEUE_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] c_PC_INC  = ADDRESS_WIDTH'(IPC);

  // Fetch-side state
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] r_req_pc;
  logic                     r_outstanding;
  logic                     r_drop;

  // Queue state
  logic [c_BW-1:0]          r_q_data [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]       r_head;
  logic [c_PTR_W-1:0]       r_tail;
  logic [c_CNT_W-1:0]       r_count;

  logic w_accept;
  logic w_resp;
  logic w_push;
  logic w_pop;
  logic w_discard;

  // A free slot at issue time is enough: with a single request in flight the
  // slot reserved here is still free when the response is pushed.
  assign IM_req     = rst_n & ~halt & ~isBranchTaken & ~r_outstanding &
                      (r_count < c_DEPTH);
  assign IM_address = r_pc;

  assign w_accept  = IM_req & IM_ready;
  // Responses without an outstanding request are stray and are ignored.
  assign w_resp    = IM_dataValid & r_outstanding;
  assign w_push    = w_resp & ~r_drop & ~isBranchTaken;
  assign w_discard = w_resp & (r_drop | isBranchTaken);
  // A pop during a redirect is irrelevant: the flush wins.
  assign w_pop     = IF_dataValid & IF_ready & ~isBranchTaken;

  assign IF_dataValid = (r_count != '0);
  assign IF_data      = r_q_data[r_head];
  assign IF_pc        = r_q_pc[r_head];
  assign queue_count  = r_count;

  // PC, request bookkeeping and stale-response tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      if (isBranchTaken) begin
        r_pc <= branchTarget;
      end else if (w_accept) begin
        r_pc <= r_pc + c_PC_INC;
      end

      if (w_accept) begin
        r_req_pc <= r_pc;
      end

      if (w_accept) begin
        r_outstanding <= 1'b1;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end

      // The in-flight response belongs to the old path; remember to drop it
      // unless it lands in the redirect cycle itself (then discarded now).
      if (isBranchTaken && r_outstanding && !IM_dataValid) begin
        r_drop <= 1'b1;
      end else if (w_resp) begin
        r_drop <= 1'b0;
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (isBranchTaken) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_q_data[r_tail] <= IM_data;
      r_q_pc[r_tail]   <= r_req_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_discarded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fetched   <= '0;
      r_stat_discarded <= '0;
    end else begin
      if (w_push) begin
        r_stat_fetched <= r_stat_fetched + 32'd1;
      end
      if (w_discard) begin
        r_stat_discarded <= r_stat_discarded + 32'd1;
      end
    end
  end

  assign stat_fetched   = r_stat_fetched;
  assign stat_discarded = r_stat_discarded;
`else
  // Without statistics the discard strobe has no consumer.
  logic w_unused_discard;
  assign w_unused_discard = w_discard;
`endif

endmodule
`default_nettype wire
